keypad_scan_ctrl: RTL
=====================

Name: keypad_scan_ctrl

Overview:
- Sequencing controller for the 4x4 keypad datapath.
- Drives the active-low column scan, synchronizes and debounces the row inputs, and decodes a confirmed press to a hex digit.
- Shifts each new digit into a two-digit history (digit0 newest, digit1 previous) that feeds the segment decoders and anode multiplexer.
- Runs on the 12 MHz HSOSC clock (CLKHF_DIV 2'b10); sits between the keypad pins and the display path.

Parameters:
- SCAN_CYCLES, 12000, dwell per column in clk cycles (1 ms); must be >= 4.
- DEBOUNCE_CYCLES, 240000, press and release debounce window in clk cycles (20 ms).
- CNT_W, 18, counter width; must hold max(SCAN_CYCLES, DEBOUNCE_CYCLES).

Ports:
- clk  input  1  system clock from HSOSC
- reset  input  1  synchronous, active-high reset
- inputrows  input  4  raw keypad rows, pulled up, active-low, asynchronous
- cols  output  4  column drive, exactly one bit low at all times
- key_valid  output  1  one-cycle pulse when a debounced press is accepted
- key_code  output  4  hex value of the most recent accepted key
- digit0  output  4  newest digit
- digit1  output  4  previous digit

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; all state changes occur on the rising edge of clk.
- Reset values: state=SCAN; col_idx=0; cols=4'b1110; counter=0; key_valid=0; key_code=0; digit0=0; digit1=0; sync flops=4'b1111.
- Row synchronizer: rows_s = inputrows delayed by a 2-flop synchronizer (2-cycle latency). Row r is pressed when rows_s[r]==0.
- Column drive: cols = ~(1<<col_idx). Advancing means col_idx wraps 3->0.
- SCAN:
  - Counter runs 0..SCAN_CYCLES-1; rows are sampled only at count==SCAN_CYCLES-1, which covers settle plus synchronizer latency.
  - If any row is low at the sample: latch col_idx, latch row = lowest-index low row, clear counter, go to DEBOUNCE. cols stays put.
  - Otherwise: advance the column, clear the counter, stay in SCAN.
- DEBOUNCE:
  - cols is frozen; the counter runs to DEBOUNCE_CYCLES-1.
  - At terminal count, if the latched row is still low: go to HELD and update the outputs on the same edge (see next item).
  - If the latched row is high at terminal count: reject the press, advance the column, go to SCAN.
  - Bounce inside the window is ignored; only the terminal sample counts.
- Accept: on the DEBOUNCE->HELD edge, key_code<=decode(col,row); digit1<=digit0; digit0<=decode(col,row); key_valid<=1. key_valid is 1 for exactly the next cycle only.
- HELD: cols frozen. When the latched row reads high: clear the counter, go to RELEASE_DB.
- RELEASE_DB:
  - Latched row goes low again before terminal count: return to HELD, no new key_valid.
  - Terminal count DEBOUNCE_CYCLES-1 with row high: advance the column, go to SCAN.
- Keys in other rows or columns while in DEBOUNCE, HELD or RELEASE_DB are ignored. No key_valid for them, even after the first key is released, unless they are still pressed at a later SCAN sample.
- Decode map (row r, col c):
  - r0 = 1 2 3 A
  - r1 = 4 5 6 B
  - r2 = 7 8 9 C
  - r3 = E 0 F D
- Reset mid-operation: any state returns to the reset values on the next edge. A pending press is discarded and the digits are cleared.
- Simultaneous events: reset dominates all other events. A terminal count and a row change in the same cycle use the synchronized row value of that cycle.

Decomposition:
- Shared package keypad_pkg holds:
  - typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE_DB} scan_state_t
  - the 16-entry KEYMAP constant, indexed {row,col}
- Sub-module row_sync: a 4-bit, 2-flop synchronizer with reset value 4'b1111. It is reusable for any future asynchronous pin.

Test Plan (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8):
- Reset for 2 cycles, no keys -> cols=1110 after reset, then 1101,1011,0111,1110 every 4 cycles; key_valid stays 0; digits stay 0.
- Hold row1 low while col2 is driven (key '6'), held 30 cycles -> one key_valid pulse; key_code=6, digit0=6, digit1=0; cols frozen at 1011 until released and release debounce completes.
- Press '6' then '0' (r3,c1), each with a full release -> second pulse gives digit0=0, digit1=6.
- Glitch row2 low for 3 cycles during col0 sample, then release -> DEBOUNCE rejects; no key_valid; scan resumes at col1.
- Hold 'A' (r0,c3), bounce release (high 3 cycles, low 2, then high 10) -> only one key_valid; next SCAN starts at col0.
- Assert reset while in HELD with digit0=5 -> next cycle: state SCAN, cols=1110, digits=0, key_valid=0.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and key map for the 4x4 keypad scan controller.
// Holds the FSM state enum, KEYMAP, and the decode helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE_DB
  } scan_state_t;

  // Indexed {row,col}; entry 0 is r0c0.
  localparam logic [15:0][3:0] KEYMAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [3:0] key_decode(
    input logic [1:0] row,
    input logic [1:0] col
  );
    return KEYMAP[{row, col}];
  endfunction

  // Lowest-index active-low row; only used when some row is low.
  function automatic logic [1:0] low_row(
    input logic [3:0] rows
  );
    logic [1:0] r;
    r = 2'd3;
    if (!rows[2]) r = 2'd2;
    if (!rows[1]) r = 2'd1;
    if (!rows[0]) r = 2'd0;
    return r;
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_row_sync.sv
// 4-bit two-flop synchronizer for asynchronous pins, resets to all ones.
// Ports: clk, reset (sync, high), d (async in), q (synchronized out).
module row_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] s1_q;
  logic [3:0] s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 4'b1111;
      s2_q <= 4'b1111;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column drive, row debounce, hex decode, 2-digit history.
// Ports: clk, reset, inputrows (async, low=press), cols, key_valid, key_code, digit0/1.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 12000,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int CNT_W           = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] inputrows,
  output logic [3:0] cols,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] digit0,
  output logic [3:0] digit1
);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  scan_state_t      state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             kv_q, kv_d;
  logic [3:0]       code_q, code_d;
  logic [3:0]       dig0_q, dig0_d;
  logic [3:0]       dig1_q, dig1_d;

  logic [3:0] rows_s;
  logic       row_hi;

  row_sync u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (inputrows),
    .q     (rows_s)
  );

  assign row_hi = rows_s[row_q];

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    kv_d    = 1'b0;
    code_d  = code_q;
    dig0_d  = dig0_q;
    dig1_d  = dig1_q;
    unique case (state_q)
      SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (rows_s != 4'b1111) begin
            row_d   = low_row(rows_s);
            state_d = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DEBOUNCE: begin
        if (cnt_q == DB_LAST) begin
          cnt_d = '0;
          if (!row_hi) begin
            state_d = HELD;
            kv_d    = 1'b1;
            code_d  = key_decode(row_q, col_q);
            dig0_d  = key_decode(row_q, col_q);
            dig1_d  = dig0_q;
          end else begin
            col_d   = col_q + 2'd1;
            state_d = SCAN;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (row_hi) begin
          cnt_d   = '0;
          state_d = RELEASE_DB;
        end
      end
      RELEASE_DB: begin
        // A re-press at any point, terminal count included, is bounce.
        if (!row_hi) begin
          state_d = HELD;
        end else if (cnt_q == DB_LAST) begin
          cnt_d   = '0;
          col_d   = col_q + 2'd1;
          state_d = SCAN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SCAN;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      cnt_q   <= '0;
      kv_q    <= 1'b0;
      code_q  <= 4'h0;
      dig0_q  <= 4'h0;
      dig1_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      kv_q    <= kv_d;
      code_q  <= code_d;
      dig0_q  <= dig0_d;
      dig1_q  <= dig1_d;
    end
  end

  always_comb begin
    cols        = 4'b1111;
    cols[col_q] = 1'b0;
  end

  assign key_valid = kv_q;
  assign key_code  = code_q;
  assign digit0    = dig0_q;
  assign digit1    = dig1_q;

endmodule
